// File: rtl/lcd_pkg.sv
// ==========================================================================
// lcd_pkg: shared geometry, command codes and colours for the LCD path (rev 1.0)
// ==========================================================================
`default_nettype none

package lcd_pkg;

  localparam int LCD_W_DEF = 132;
  localparam int LCD_H_DEF = 162;

  localparam logic [1:0] OP_SET    = 2'b00;
  localparam logic [1:0] OP_CLR    = 2'b01;
  localparam logic [1:0] OP_XOR    = 2'b10;
  localparam logic [1:0] OP_CLRROW = 2'b11;

  localparam logic COL_TOP = 1'b1;
  localparam logic COL_BG  = 1'b0;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_RMW_WR = 3'd3,
    ST_FILL   = 3'd4
  } fb_state_t;

  // Column 0 sits in the MSB of the row word.
  function automatic logic [7:0] bit_idx(input int w, input logic [7:0] x);
    return 8'(w - 1) - x;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_frame_buffer_if.sv
// ==========================================================================
// lcd_frame_buffer_if: drawing command, swap and LCD row-read signals (rev 1.0)
// ==========================================================================
`default_nettype none

interface lcd_frame_buffer_if import lcd_pkg::*; #(
  parameter int LCD_W = LCD_W_DEF
);
  logic             wr_valid;
  logic             wr_ready;
  logic [1:0]       wr_op;
  logic [7:0]       wr_x;
  logic [7:0]       wr_y;
  logic             wr_err;
  logic             fill_req;
  logic             fill_val;
  logic             swap_req;
  logic             swap_done;
  logic             busy;
  logic             front_bank;
  logic             ram_lcd_clk_en;
  logic [7:0]       ram_lcd_addr;
  logic [LCD_W-1:0] ram_lcd_data;

  modport slave (
    input  wr_valid, wr_op, wr_x, wr_y, fill_req, fill_val, swap_req,
           ram_lcd_clk_en, ram_lcd_addr,
    output wr_ready, wr_err, swap_done, busy, front_bank, ram_lcd_data
  );

  modport master (
    output wr_valid, wr_op, wr_x, wr_y, fill_req, fill_val, swap_req,
           ram_lcd_clk_en, ram_lcd_addr,
    input  wr_ready, wr_err, swap_done, busy, front_bank, ram_lcd_data
  );
endinterface

`default_nettype wire

// File: rtl/lcd_fb_bank.sv
// ==========================================================================
// lcd_fb_bank: one LCD_H x LCD_W bit bank, sync write, comb + registered read (rev 1.0)
// ==========================================================================
`default_nettype none

module lcd_fb_bank import lcd_pkg::*; #(
  parameter int LCD_W = LCD_W_DEF,
  parameter int LCD_H = LCD_H_DEF
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_we,
  input  wire logic [7:0]       i_waddr,
  input  wire logic [LCD_W-1:0] i_wdata,
  input  wire logic [7:0]       i_raddr,
  output logic      [LCD_W-1:0] o_rdata,
  input  wire logic             i_lcd_en,
  input  wire logic [7:0]       i_lcd_addr,
  output logic      [LCD_W-1:0] o_lcd_data
);

  localparam logic [7:0] c_H8 = 8'(LCD_H);

  logic [LCD_W-1:0] r_mem [LCD_H];
  logic [LCD_W-1:0] r_lcd_data;

  always_ff @(posedge clk) begin
    if (i_we && (i_waddr < c_H8)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = (i_raddr < c_H8) ? r_mem[i_raddr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lcd_data <= '0;
    end else if (i_lcd_en) begin
      r_lcd_data <= (i_lcd_addr < c_H8) ? r_mem[i_lcd_addr] : '0;
    end
  end

  assign o_lcd_data = r_lcd_data;

endmodule

`default_nettype wire

// File: rtl/lcd_frame_buffer.sv
// ==========================================================================
// lcd_frame_buffer: double-buffered 1bpp frame store with frame-aligned swap (rev 1.0)
// ==========================================================================
`default_nettype none

module lcd_frame_buffer import lcd_pkg::*; #(
  parameter int LCD_W = LCD_W_DEF,
  parameter int LCD_H = LCD_H_DEF
) (
  input wire logic      clk,
  input wire logic      rst,
  lcd_frame_buffer_if.slave bus
);

  localparam logic [7:0] c_W8    = 8'(LCD_W);
  localparam logic [7:0] c_H8    = 8'(LCD_H);
  localparam logic [7:0] c_HLAST = 8'(LCD_H - 1);

  fb_state_t        r_state;
  logic [7:0]       r_row;
  logic             r_init_bank;
  logic [1:0]       r_op;
  logic [7:0]       r_x;
  logic [7:0]       r_y;
  logic [LCD_W-1:0] r_rmw_row;
  logic             r_fill_pend;
  logic             r_fill_val;
  logic             r_fill_cur;
  logic             r_swap_pend;
  logic             r_front;
  logic             r_lcd_sel;
  logic             r_wr_err;
  logic             r_swap_done;

  logic             w_idle;
  logic             w_wr_ready;
  logic             w_accept;
  logic             w_in_range;
  logic             w_start_fill;
  logic             w_swap_now;
  logic             w_we;
  logic             w_wbank;
  logic [7:0]       w_waddr;
  logic [LCD_W-1:0] w_wdata;
  logic [LCD_W-1:0] w_bit;
  logic [LCD_W-1:0] w_rmw_new;
  logic [LCD_W-1:0] w_back_rdata;
  logic [LCD_W-1:0] w_rd_data  [2];
  logic [LCD_W-1:0] w_lcd_data [2];

  assign w_idle       = (r_state == ST_IDLE);
  assign w_wr_ready   = w_idle && !r_fill_pend;
  assign w_accept     = bus.wr_valid && w_wr_ready;
  assign w_in_range   = (bus.wr_x < c_W8) && (bus.wr_y < c_H8);
  assign w_start_fill = w_idle && r_fill_pend;
  // Swap only while the driver fetches row 0, so the panel sees whole frames.
  assign w_swap_now   = bus.ram_lcd_clk_en && (bus.ram_lcd_addr == 8'd0) &&
                        w_idle && !r_fill_pend && r_swap_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_row       <= 8'd0;
      r_init_bank <= 1'b0;
      r_op        <= OP_SET;
      r_x         <= 8'd0;
      r_y         <= 8'd0;
      r_rmw_row   <= '0;
      r_fill_pend <= 1'b0;
      r_fill_val  <= 1'b0;
      r_fill_cur  <= 1'b0;
      r_swap_pend <= 1'b0;
      r_front     <= 1'b0;
      r_lcd_sel   <= 1'b0;
      r_wr_err    <= 1'b0;
      r_swap_done <= 1'b0;
    end else begin
      r_wr_err    <= w_accept && !w_in_range;
      r_swap_done <= w_swap_now;
      r_fill_pend <= bus.fill_req || (r_fill_pend && !w_start_fill);
      r_swap_pend <= bus.swap_req || (r_swap_pend && !w_swap_now);
      if (bus.fill_req) r_fill_val <= bus.fill_val;
      if (w_swap_now) r_front <= ~r_front;
      if (bus.ram_lcd_clk_en) r_lcd_sel <= r_front ^ w_swap_now;

      case (r_state)
        ST_INIT: begin
          r_row <= r_row + 8'd1;
          if (r_row == c_HLAST) begin
            r_row       <= 8'd0;
            r_init_bank <= ~r_init_bank;
            if (r_init_bank) r_state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (w_start_fill) begin
            r_state    <= ST_FILL;
            r_row      <= 8'd0;
            r_fill_cur <= r_fill_val;
          end else if (w_accept && w_in_range) begin
            r_state <= ST_RMW_RD;
            r_op    <= bus.wr_op;
            r_x     <= bus.wr_x;
            r_y     <= bus.wr_y;
          end
        end
        ST_RMW_RD: begin
          r_rmw_row <= w_back_rdata;
          r_state   <= ST_RMW_WR;
        end
        ST_RMW_WR: r_state <= ST_IDLE;
        ST_FILL: begin
          r_row <= r_row + 8'd1;
          if (r_row == c_HLAST) r_state <= ST_IDLE;
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign w_bit = {{(LCD_W-1){1'b0}}, 1'b1} << bit_idx(LCD_W, r_x);

  always_comb begin
    w_rmw_new = r_rmw_row;
    case (r_op)
      OP_SET:    w_rmw_new = (r_rmw_row & ~w_bit) | (w_bit & {LCD_W{COL_TOP}});
      OP_CLR:    w_rmw_new = (r_rmw_row & ~w_bit) | (w_bit & {LCD_W{COL_BG}});
      OP_XOR:    w_rmw_new = r_rmw_row ^ w_bit;
      OP_CLRROW: w_rmw_new = {LCD_W{COL_BG}};
      default:   w_rmw_new = r_rmw_row;
    endcase
  end

  always_comb begin
    w_we    = 1'b0;
    w_wbank = ~r_front;
    w_waddr = r_row;
    w_wdata = {LCD_W{COL_BG}};
    case (r_state)
      ST_INIT: begin
        w_we    = 1'b1;
        w_wbank = r_init_bank;
      end
      ST_FILL: begin
        w_we    = 1'b1;
        w_wdata = {LCD_W{r_fill_cur}};
      end
      ST_RMW_WR: begin
        w_we    = 1'b1;
        w_waddr = r_y;
        w_wdata = w_rmw_new;
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < 2; i++) begin : g_bank
    lcd_fb_bank #(.LCD_W(LCD_W), .LCD_H(LCD_H)) u_bank (
      .clk        (clk),
      .rst        (rst),
      .i_we       (w_we && (w_wbank == 1'(i))),
      .i_waddr    (w_waddr),
      .i_wdata    (w_wdata),
      .i_raddr    (r_y),
      .o_rdata    (w_rd_data[i]),
      .i_lcd_en   (bus.ram_lcd_clk_en),
      .i_lcd_addr (bus.ram_lcd_addr),
      .o_lcd_data (w_lcd_data[i])
    );
  end

  assign w_back_rdata     = r_front ? w_rd_data[0] : w_rd_data[1];
  assign bus.wr_ready     = w_wr_ready;
  assign bus.wr_err       = r_wr_err;
  assign bus.swap_done    = r_swap_done;
  assign bus.busy         = !w_idle || r_fill_pend || r_swap_pend;
  assign bus.front_bank   = r_front;
  assign bus.ram_lcd_data = r_lcd_sel ? w_lcd_data[1] : w_lcd_data[0];

endmodule

`default_nettype wire

// File: tb/tb_lcd_frame_buffer.sv
// ==========================================================================
// tb_lcd_frame_buffer: scoreboarded random + directed bench for lcd_frame_buffer (rev 1.0)
// ==========================================================================
`default_nettype none

module tb_lcd_frame_buffer;
  import lcd_pkg::*;

  localparam int W = 132;
  localparam int H = 162;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_frame_buffer_if #(.LCD_W(W)) bus();
  lcd_frame_buffer #(.LCD_W(W), .LCD_H(H)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Reference: two whole frames plus which one is on screen.
  logic [W-1:0] mem [2][H];
  bit           front;
  bit           swap_pend;
  logic [W-1:0] exp_q [$];
  logic         rd_v = 1'b0;
  int           n_vec = 0;
  int           n_err = 0;

  task automatic chkv(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(posedge clk) rd_v <= bus.ram_lcd_clk_en;

  always @(negedge clk) begin : mon
    logic [W-1:0] e;
    if (rd_v === 1'b1) begin
      if (exp_q.size() == 0) begin
        chki("rd_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chkv("rd_data", bus.ram_lcd_data, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < H; r++) mem[b][r] = '0;
    front     = 1'b0;
    swap_pend = 1'b0;
  endtask

  task automatic model_op(input int op, input int x, input int y);
    bit b;
    b = ~front;
    if (x < W && y < H) begin
      case (op)
        0: mem[b][y][W-1-x] = 1'b1;
        1: mem[b][y][W-1-x] = 1'b0;
        2: mem[b][y][W-1-x] = ~mem[b][y][W-1-x];
        default: mem[b][y] = '0;
      endcase
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.wr_ready === 1'b1) break;
      n++;
      if (n > 2000) begin
        chki("idle_timeout", n, 0);
        break;
      end
    end
    tick();
  endtask

  task automatic do_op(input int op, input int x, input int y);
    bit         inr;
    int         n;
    logic       rdy;
    logic [2:0] rp;
    inr = (x < W) && (y < H);
    bus.wr_valid = 1'b1;
    bus.wr_op    = 2'(op);
    bus.wr_x     = 8'(x);
    bus.wr_y     = 8'(y);
    n = 0;
    forever begin
      @(negedge clk);
      rdy = bus.wr_ready;
      tick();
      if (rdy === 1'b1) break;
      n++;
      if (n > 2000) begin
        chki("op_accept_timeout", n, 0);
        break;
      end
    end
    bus.wr_valid = 1'b0;
    model_op(op, x, y);
    @(negedge clk);
    chk1("wr_err", bus.wr_err, !inr);
    rp[0] = bus.wr_ready;
    @(negedge clk);
    chk1("wr_err_pulse", bus.wr_err, 1'b0);
    rp[1] = bus.wr_ready;
    @(negedge clk);
    rp[2] = bus.wr_ready;
    chki("wr_ready_pattern", int'(rp), inr ? 4 : 7);
    tick();
  endtask

  task automatic rd(input int a, input bit can_swap);
    bit sw;
    sw = (a == 0) && swap_pend && can_swap;
    if (sw) begin
      front     = ~front;
      swap_pend = 1'b0;
    end
    if (a < H) exp_q.push_back(mem[front][a]);
    else       exp_q.push_back('0);
    bus.ram_lcd_clk_en = 1'b1;
    bus.ram_lcd_addr   = 8'(a);
    tick();
    bus.ram_lcd_clk_en = 1'b0;
    @(negedge clk);
    chk1("swap_done", bus.swap_done, sw);
    chk1("front_bank", bus.front_bank, front);
    tick();
  endtask

  task automatic do_swap();
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    swap_pend = 1'b1;
  endtask

  task automatic pulse_fill(input bit v);
    bus.fill_req = 1'b1;
    bus.fill_val = v;
    tick();
    bus.fill_req = 1'b0;
    for (int r = 0; r < H; r++) mem[~front][r] = {W{v}};
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int cnt;
    bus.wr_valid = 1'b0; bus.wr_op = 2'b00; bus.wr_x = 8'd0; bus.wr_y = 8'd0;
    bus.fill_req = 1'b0; bus.fill_val = 1'b0; bus.swap_req = 1'b0;
    bus.ram_lcd_clk_en = 1'b0; bus.ram_lcd_addr = 8'd0;
    model_clear();

    repeat (3) tick();
    @(negedge clk);
    chk1("rst_wr_ready", bus.wr_ready, 1'b0);
    chk1("rst_wr_err", bus.wr_err, 1'b0);
    chk1("rst_swap_done", bus.swap_done, 1'b0);
    chk1("rst_busy", bus.busy, 1'b1);
    chk1("rst_front", bus.front_bank, 1'b0);
    chkv("rst_data", bus.ram_lcd_data, '0);
    tick();
    rst = 1'b0;

    // INIT must take exactly two banks' worth of rows.
    repeat (2*H-1) tick();
    @(negedge clk);
    chk1("init_busy", bus.busy, 1'b1);
    tick();
    repeat (2) tick();
    @(negedge clk);
    chk1("init_done_busy", bus.busy, 1'b0);
    chk1("init_done_ready", bus.wr_ready, 1'b1);
    tick();
    for (int r = 0; r < H; r++) rd(r, 1'b1);
    rd(H, 1'b1);
    rd(255, 1'b1);
    do_swap();
    for (int r = 0; r < H; r++) rd(r, 1'b1);

    do_op(0, 0, 5);
    do_swap();
    rd(0, 1'b1); rd(5, 1'b1); rd(4, 1'b1); rd(6, 1'b1);

    do_op(2, 131, 161);
    do_op(2, 131, 161);
    do_op(2, 130, 161);
    do_swap();
    rd(0, 1'b1); rd(161, 1'b1);

    do_op(0, 132, 5);
    do_op(1, 5, 162);
    do_op(3, 0, 200);
    do_op(2, 255, 255);
    do_swap();
    rd(0, 1'b1); rd(5, 1'b1); rd(162, 1'b1);

    // Fill outranks a waiting pixel command.
    pulse_fill(1'b1);
    bus.wr_valid = 1'b1; bus.wr_op = OP_CLR; bus.wr_x = 8'd7; bus.wr_y = 8'd3;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (bus.wr_ready === 1'b1) break;
      cnt++;
      if (cnt > 2000) break;
    end
    chki("fill_ready_low", cnt, H + 1);
    tick();
    bus.wr_valid = 1'b0;
    model_op(1, 7, 3);
    wait_idle();
    do_swap();
    rd(0, 1'b1); rd(3, 1'b1); rd(80, 1'b1); rd(161, 1'b1);

    for (int r = 0; r < 6; r++) begin
      if ($urandom_range(0, 2) == 0) begin
        pulse_fill(1'($urandom_range(0, 1)));
        wait_idle();
      end
      for (int k = 0; k < 16; k++) begin
        int op, x, y;
        op = $urandom_range(0, 3);
        x  = ($urandom_range(0, 7) == 0) ? $urandom_range(W, 255) : $urandom_range(0, W-1);
        y  = ($urandom_range(0, 7) == 0) ? $urandom_range(H, 255) :
             (($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, H-1));
        do_op(op, x, y);
      end
      do_swap();
      for (int a = 0; a < 8; a++) rd(a, 1'b1);
      for (int k = 0; k < 6; k++) rd($urandom_range(1, 255), 1'b1);
    end

    // Swap requested during a fill must wait for a row-0 read after IDLE.
    pulse_fill(1'b1);
    do_swap();
    rd(0, 1'b0);
    repeat (20) tick();
    rd(0, 1'b0);
    wait_idle();
    @(negedge clk);
    chk1("swap_pending_busy", bus.busy, 1'b1);
    tick();
    rd(3, 1'b1);
    rd(0, 1'b1);
    rd(100, 1'b1);

    // Reset in the middle of a fill.
    bus.fill_req = 1'b1; bus.fill_val = 1'b1;
    tick();
    bus.fill_req = 1'b0;
    repeat (30) tick();
    rst = 1'b1;
    @(negedge clk);
    chk1("midrst_busy", bus.busy, 1'b1);
    chk1("midrst_ready", bus.wr_ready, 1'b0);
    chk1("midrst_front", bus.front_bank, 1'b0);
    chkv("midrst_data", bus.ram_lcd_data, '0);
    tick();
    rst = 1'b0;
    model_clear();
    repeat (2*H+2) tick();
    @(negedge clk);
    chk1("reinit_busy", bus.busy, 1'b0);
    chk1("reinit_ready", bus.wr_ready, 1'b1);
    tick();
    for (int a = 0; a < 4; a++) rd(a, 1'b1);
    do_op(0, 10, 2);
    do_swap();
    for (int a = 0; a < 4; a++) rd(a, 1'b1);

    repeat (3) tick();
    chki("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
